vote_tally_engine: RTL and testbench

//  Parametrised N-candidate ballot block: debounces NUM_CAND buttons and gates voting through an officer-armed session FSM.

---
 rtl/vote_pkg.sv | 27 ++
 rtl/vote_button_debounce.sv | 47 ++++
 rtl/vote_tally_engine.sv | 183 ++++++++++++++++++
 tb/tb_vote_tally_engine.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/vote_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | vote_pkg                                                              |
// | Shared types, defaults and helpers for the ballot datapath.           |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package vote_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CONFIRM = 2'd2
  } vote_state_e;

  localparam int DEFAULT_CNT_W    = 8;
  localparam int DEFAULT_DEBOUNCE = 10;

  // True when exactly one bit of v is set; callers zero-extend to 16 bits.
  function automatic logic pop_is_one(input logic [15:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 16; i++) n += int'(v[i]);
    return (n == 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vote_button_debounce.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | vote_button_debounce                                                  |
// | Emits one press pulse after DEBOUNCE_CYC consecutive high cycles.     |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module vote_button_debounce
  import vote_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEFAULT_DEBOUNCE
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic press_pulse_o
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q, pulse_d;

  // Count saturates at DEBOUNCE_CYC, so a held button pulses only once.
  always_comb begin
    cnt_d   = cnt_q;
    pulse_d = btn_i && (cnt_q == CW'(DEBOUNCE_CYC - 1));
    if (!btn_i) begin
      cnt_d = '0;
    end else if (cnt_q != CW'(DEBOUNCE_CYC)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign press_pulse_o = pulse_q;

endmodule
`default_nettype wire

// File: rtl/vote_tally_engine.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | vote_tally_engine                                                     |
// | Armed-ballot voting block with saturating tallies and leader scan.    |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module vote_tally_engine
  import vote_pkg::*;
#(
  parameter int NUM_CAND     = 4,
  parameter int CNT_W        = DEFAULT_CNT_W,
  parameter int DEBOUNCE_CYC = DEFAULT_DEBOUNCE,
  parameter int HOLD_CYC     = 10,
  parameter int SEL_W        = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mode_i,
  input  logic                arm_i,
  input  logic [NUM_CAND-1:0] button_i,
  input  logic [SEL_W-1:0]    sel_i,
  output logic [CNT_W-1:0]    led_o,
  output logic                ready_o,
  output logic                vote_ack_o,
  output logic                vote_err_o,
  output logic                sat_o,
  output logic [CNT_W-1:0]    total_o,
  output logic [SEL_W-1:0]    leader_o,
  output logic                leader_tie_o
);

  localparam int             HW   = $clog2(HOLD_CYC + 1);
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic [NUM_CAND-1:0] press;

  for (genvar g = 0; g < NUM_CAND; g++) begin : g_debounce
    vote_button_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
      .clk          (clk),
      .reset        (reset),
      .btn_i        (button_i[g]),
      .press_pulse_o(press[g])
    );
  end

  vote_state_e      state_q, state_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [CNT_W-1:0] tally_q [NUM_CAND];
  logic [CNT_W-1:0] tally_d [NUM_CAND];
  logic [CNT_W-1:0] total_q, total_d;
  logic [CNT_W-1:0] led_q, led_d;
  logic             sat_q, sat_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic             ready_q, ready_d;
  logic             press_one;
  logic [SEL_W-1:0] press_idx;

  always_comb begin
    press_idx = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (press[i]) press_idx = SEL_W'(i);
    end
    press_one = pop_is_one(16'(press));
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    tally_d = tally_q;
    total_d = total_q;
    sat_d   = sat_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (arm_i && !mode_i) state_d = ARMED;
      end
      ARMED: begin
        // Switching to result mode cancels the ballot before any press counts.
        if (mode_i) begin
          state_d = IDLE;
        end else if (press_one) begin
          if (tally_q[press_idx] == CMAX) sat_d = 1'b1;
          else tally_d[press_idx] = tally_q[press_idx] + 1'b1;
          if (total_q != CMAX) total_d = total_q + 1'b1;
          ack_d   = 1'b1;
          hold_d  = '0;
          state_d = CONFIRM;
        end else if (|press) begin
          err_d = 1'b1;
        end
      end
      CONFIRM: begin
        if (hold_q == HW'(HOLD_CYC - 1)) state_d = IDLE;
        else hold_d = hold_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == ARMED);
    led_d   = '0;
    if (mode_i) begin
      if (32'(sel_i) < NUM_CAND) led_d = tally_q[sel_i];
    end else if (state_d == CONFIRM) begin
      led_d = CMAX;
    end
  end

  // Background leader scan: one candidate per cycle, published at pass end.
  logic [SEL_W-1:0] scan_q, scan_d, ridx_q, ridx_d, leader_q, leader_d;
  logic [CNT_W-1:0] rmax_q, rmax_d, cur;
  logic             rtie_q, rtie_d, ltie_q, ltie_d, last;

  always_comb begin
    cur      = tally_q[scan_q];
    last     = (scan_q == SEL_W'(NUM_CAND - 1));
    rmax_d   = rmax_q;
    ridx_d   = ridx_q;
    rtie_d   = rtie_q;
    leader_d = leader_q;
    ltie_d   = ltie_q;
    if (scan_q == '0 || cur > rmax_q) begin
      rmax_d = cur;
      ridx_d = scan_q;
      rtie_d = 1'b0;
    end else if (cur == rmax_q) begin
      rtie_d = 1'b1;
    end
    scan_d = last ? '0 : scan_q + 1'b1;
    if (last) begin
      leader_d = ridx_d;
      ltie_d   = rtie_d && (rmax_d != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      hold_q   <= '0;
      total_q  <= '0;
      led_q    <= '0;
      sat_q    <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      ready_q  <= 1'b0;
      scan_q   <= '0;
      ridx_q   <= '0;
      rmax_q   <= '0;
      rtie_q   <= 1'b0;
      leader_q <= '0;
      ltie_q   <= 1'b0;
      for (int i = 0; i < NUM_CAND; i++) tally_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      total_q  <= total_d;
      led_q    <= led_d;
      sat_q    <= sat_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      ready_q  <= ready_d;
      scan_q   <= scan_d;
      ridx_q   <= ridx_d;
      rmax_q   <= rmax_d;
      rtie_q   <= rtie_d;
      leader_q <= leader_d;
      ltie_q   <= ltie_d;
      for (int i = 0; i < NUM_CAND; i++) tally_q[i] <= tally_d[i];
    end
  end

  assign led_o        = led_q;
  assign ready_o      = ready_q;
  assign vote_ack_o   = ack_q;
  assign vote_err_o   = err_q;
  assign sat_o        = sat_q;
  assign total_o      = total_q;
  assign leader_o     = leader_q;
  assign leader_tie_o = ltie_q;

endmodule
`default_nettype wire

// File: tb/tb_vote_tally_engine.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_vote_tally_engine                                                  |
// | Directed self-checking bench for vote_tally_engine.                   |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_vote_tally_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1, mode = 1'b0, arm = 1'b0;
  logic [3:0] button = '0;
  logic [1:0] sel = '0;
  logic [7:0] led, total;
  logic       ready, ack, err, sat, tie;
  logic [1:0] leader;

  logic       mode2 = 1'b0, arm2 = 1'b0;
  logic [3:0] button2 = '0;
  logic [1:0] sel2 = '0;
  logic [3:0] led2, total2;
  logic       ready2, ack2, err2, sat2, tie2;
  logic [1:0] leader2;

  vote_tally_engine #(.NUM_CAND(4), .CNT_W(8), .DEBOUNCE_CYC(10), .HOLD_CYC(10), .SEL_W(2)) dut (
    .clk(clk), .reset(reset), .mode_i(mode), .arm_i(arm), .button_i(button), .sel_i(sel),
    .led_o(led), .ready_o(ready), .vote_ack_o(ack), .vote_err_o(err), .sat_o(sat),
    .total_o(total), .leader_o(leader), .leader_tie_o(tie)
  );

  vote_tally_engine #(.NUM_CAND(4), .CNT_W(4), .DEBOUNCE_CYC(2), .HOLD_CYC(2), .SEL_W(2)) dut_sat (
    .clk(clk), .reset(reset), .mode_i(mode2), .arm_i(arm2), .button_i(button2), .sel_i(sel2),
    .led_o(led2), .ready_o(ready2), .vote_ack_o(ack2), .vote_err_o(err2), .sat_o(sat2),
    .total_o(total2), .leader_o(leader2), .leader_tie_o(tie2)
  );

  int checks = 0, errors = 0;
  int ack_cnt = 0, err_cnt = 0, ones_cnt = 0, ack2_cnt = 0;

  always @(negedge clk) begin
    if (ack === 1'b1) ack_cnt++;
    if (err === 1'b1) err_cnt++;
    if (led === 8'hFF) ones_cnt++;
    if (ack2 === 1'b1) ack2_cnt++;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cast_vote(input int idx);
    arm = 1'b1; tick(1); arm = 1'b0;
    button[idx] = 1'b1; tick(10); button[idx] = 1'b0;
    tick(13);
  endtask

  task automatic test_reset;
    reset = 1'b1; tick(2); reset = 1'b0;
    checks++; if (led !== 8'h00) begin errors++; $display("FAIL reset_led: got %0h expected 0", led); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0b expected 0", ready); end
    checks++; if ({ack, err, sat, tie} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {ack, err, sat, tie}); end
    checks++; if (total !== 8'd0 || leader !== 2'd0) begin errors++; $display("FAIL reset_total_leader: got %0d/%0d expected 0/0", total, leader); end
  endtask

  task automatic test_single_vote;
    int a0, o0;
    a0 = ack_cnt; o0 = ones_cnt;
    arm = 1'b1; tick(1); arm = 1'b0;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL arm_ready: got %0b expected 1", ready); end
    button[2] = 1'b1; tick(10); button[2] = 1'b0;
    tick(1);
    checks++; if (ack !== 1'b1 || led !== 8'hFF) begin errors++; $display("FAIL vote_ack_led: got ack=%0b led=%0h expected 1/ff", ack, led); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL vote_ready_drop: got %0b expected 0", ready); end
    tick(14);
    checks++; if (ack_cnt - a0 !== 1) begin errors++; $display("FAIL vote_ack_count: got %0d expected 1", ack_cnt - a0); end
    checks++; if (ones_cnt - o0 !== 10) begin errors++; $display("FAIL confirm_hold: got %0d expected 10", ones_cnt - o0); end
    checks++; if (led !== 8'h00 || total !== 8'd1) begin errors++; $display("FAIL after_confirm: got led=%0h total=%0d expected 0/1", led, total); end
    mode = 1'b1; sel = 2'd2; tick(1);
    checks++; if (led !== 8'd1) begin errors++; $display("FAIL tally2: got %0d expected 1", led); end
    mode = 1'b0; tick(1);
  endtask

  task automatic test_ignored_presses;
    int a0;
    a0 = ack_cnt;
    button[0] = 1'b1; tick(20); button[0] = 1'b0; tick(3);
    checks++; if (ack_cnt - a0 !== 0 || total !== 8'd1) begin errors++; $display("FAIL idle_press: got acks=%0d total=%0d expected 0/1", ack_cnt - a0, total); end
    arm = 1'b1; tick(1); arm = 1'b0;
    button[1] = 1'b1; tick(9); button[1] = 1'b0; tick(5);
    checks++; if (ack_cnt - a0 !== 0 || ready !== 1'b1) begin errors++; $display("FAIL short_press: got acks=%0d ready=%0b expected 0/1", ack_cnt - a0, ready); end
    mode = 1'b1; tick(1);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL cancel_ready: got %0b expected 0", ready); end
    mode = 1'b0; tick(1);
  endtask

  task automatic test_multi_press;
    int a0, e0;
    a0 = ack_cnt; e0 = err_cnt;
    arm = 1'b1; tick(1); arm = 1'b0;
    button = 4'b1001; tick(10); button = 4'b0000; tick(3);
    checks++; if (err_cnt - e0 !== 1 || ack_cnt - a0 !== 0) begin errors++; $display("FAIL multi_err: got err=%0d ack=%0d expected 1/0", err_cnt - e0, ack_cnt - a0); end
    checks++; if (ready !== 1'b1 || total !== 8'd1) begin errors++; $display("FAIL multi_state: got ready=%0b total=%0d expected 1/1", ready, total); end
    mode = 1'b1; tick(1); mode = 1'b0; tick(1);
  endtask

  task automatic test_saturation;
    int a0;
    a0 = ack2_cnt;
    for (int v = 0; v < 17; v++) begin
      arm2 = 1'b1; tick(1); arm2 = 1'b0;
      button2[1] = 1'b1; tick(2); button2[1] = 1'b0; tick(4);
      if (v == 13) begin
        checks++; if (sat2 !== 1'b0 || total2 !== 4'd14) begin errors++; $display("FAIL pre_sat: got sat=%0b total=%0d expected 0/14", sat2, total2); end
      end
    end
    checks++; if (sat2 !== 1'b1 || total2 !== 4'd15) begin errors++; $display("FAIL sat_total: got sat=%0b total=%0d expected 1/15", sat2, total2); end
    checks++; if (ack2_cnt - a0 !== 17) begin errors++; $display("FAIL sat_acks: got %0d expected 17", ack2_cnt - a0); end
    mode2 = 1'b1; sel2 = 2'd1; tick(1);
    checks++; if (led2 !== 4'd15) begin errors++; $display("FAIL sat_tally1: got %0d expected 15", led2); end
    sel2 = 2'd0; tick(1);
    checks++; if (led2 !== 4'd0) begin errors++; $display("FAIL sat_tally0: got %0d expected 0", led2); end
    mode2 = 1'b0;
  endtask

  task automatic test_leader;
    reset = 1'b1; tick(1); reset = 1'b0;
    for (int k = 0; k < 3; k++) cast_vote(0);
    for (int k = 0; k < 5; k++) cast_vote(1);
    for (int k = 0; k < 5; k++) cast_vote(2);
    cast_vote(3);
    tick(8);
    checks++; if (leader !== 2'd1 || tie !== 1'b1) begin errors++; $display("FAIL leader_tie: got %0d/%0b expected 1/1", leader, tie); end
    checks++; if (total !== 8'd14) begin errors++; $display("FAIL total14: got %0d expected 14", total); end
    cast_vote(2);
    tick(8);
    checks++; if (leader !== 2'd2 || tie !== 1'b0) begin errors++; $display("FAIL leader_new: got %0d/%0b expected 2/0", leader, tie); end
  endtask

  task automatic test_result_and_abort;
    int a0;
    mode = 1'b1; sel = 2'd2; tick(1);
    checks++; if (led !== 8'd6) begin errors++; $display("FAIL result_sel2: got %0d expected 6", led); end
    sel = 2'd0; tick(1);
    checks++; if (led !== 8'd3) begin errors++; $display("FAIL result_sel0: got %0d expected 3", led); end
    mode = 1'b0; tick(1);
    a0 = ack_cnt;
    arm = 1'b1; tick(1); arm = 1'b0;
    mode = 1'b1; tick(1); mode = 1'b0;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL abort_ready: got %0b expected 0", ready); end
    button[0] = 1'b1; tick(10); button[0] = 1'b0; tick(3);
    checks++; if (ack_cnt - a0 !== 0 || total !== 8'd15) begin errors++; $display("FAIL abort_discard: got acks=%0d total=%0d expected 0/15", ack_cnt - a0, total); end
    arm = 1'b1; tick(1); arm = 1'b0;
    button[3] = 1'b1; tick(10); button[3] = 1'b0; tick(3);
    checks++; if (led !== 8'hFF) begin errors++; $display("FAIL confirm_led: got %0h expected ff", led); end
    reset = 1'b1; tick(1); reset = 1'b0;
    checks++; if (led !== 8'h00 || total !== 8'd0) begin errors++; $display("FAIL reset_confirm: got led=%0h total=%0d expected 0/0", led, total); end
    mode = 1'b1; sel = 2'd1; tick(1);
    checks++; if (led !== 8'd0) begin errors++; $display("FAIL reset_tally1: got %0d expected 0", led); end
    mode = 1'b0; tick(1);
  endtask

  initial begin
    tick(1);
    test_reset();
    test_single_vote();
    test_ignored_presses();
    test_multi_press();
    test_saturation();
    test_leader();
    test_result_and_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
